ps2_kbscan: RTL



---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_keymap.sv | 24 ++
 rtl/ps2_kbscan.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keyboard front end
//   ps2_state_e : receive FSM states
//   PS2_EXT/BRK : Set-2 prefix bytes
//   PS2_*SHIFT/CTRL : modifier scancodes
//   L3_NOKEY    : keymap value for an unmapped code
package ps2_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_e;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;
    localparam logic [7:0] PS2_CTRL   = 8'h14;
    localparam logic [6:0] L3_NOKEY   = 7'h7F;
endpackage

// File: rtl/ps2_keymap.sv
// ps2_keymap: combinational Set-2 to L3 key code table
//   i_key : {ext, scancode[6:0]}
//   o_l3  : L3 key code, L3_NOKEY when unmapped
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] i_key,
    output logic [6:0] o_l3
);
    always_comb begin
        o_l3 = L3_NOKEY;
        case (i_key)
            8'h1C: o_l3 = 7'h41;
            8'h32: o_l3 = 7'h42;
            8'h45: o_l3 = 7'h30;
            8'h5A: o_l3 = 7'h0D;
            8'h29: o_l3 = 7'h20;
            8'h66: o_l3 = 7'h08;
            8'hF5: o_l3 = 7'h1E;
            8'hF2: o_l3 = 7'h1F;
            default: o_l3 = L3_NOKEY;
        endcase
    end
endmodule

// File: rtl/ps2_kbscan.sv
// ps2_kbscan: PS/2 keyboard receiver, prefix decoder and L3 key translator
//   clk, rst            : system clock, async active-high reset
//   ps2_clk, ps2_dat    : raw PS/2 pins
//   kb_code             : {held, l3code}, 8'h00 when no key
//   kb_shift, kb_ctrl   : modifier levels
//   scan_stb, scan_byte : one-cycle pulse with last good frame byte
//   frame_err           : one-cycle pulse on parity/start/stop error or timeout
module ps2_kbscan
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] kb_code,
    output logic       kb_shift,
    output logic       kb_ctrl,
    output logic       scan_stb,
    output logic [7:0] scan_byte,
    output logic       frame_err
);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [1:0]    r_clk_s, r_dat_s;
    logic [FW-1:0] r_fcnt;
    logic          r_filt;
    ps2_state_e    r_state, w_next;
    logic [2:0]    r_bits;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [TW-1:0] r_tmo;
    logic          r_ext, r_brk;
    logic          w_fe, w_dat, w_tmo, w_par_ok, w_stb, w_err;
    logic [6:0]    w_l3;
    assign w_dat    = r_dat_s[1];
    // fe fires on the FILT_LEN-th consecutive low sample, the cycle the filtered level falls
    assign w_fe     = r_filt && !r_clk_s[1] && r_fcnt == FW'(FILT_LEN - 1);
    assign w_tmo    = r_state != ST_IDLE && !w_fe && r_tmo == TW'(TIMEOUT - 1);
    assign w_par_ok = ^{r_shift, r_par};
    // pins idle high, so synchronizers and filter reset high to avoid a spurious edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s <= 2'b11;
            r_dat_s <= 2'b11;
            r_fcnt  <= '0;
            r_filt  <= 1'b1;
        end else begin
            r_clk_s <= {r_clk_s[0], ps2_clk};
            r_dat_s <= {r_dat_s[0], ps2_dat};
            if (r_clk_s[1] == r_filt) r_fcnt <= '0;
            else if (r_fcnt == FW'(FILT_LEN - 1)) begin
                r_fcnt <= '0;
                r_filt <= r_clk_s[1];
            end else r_fcnt <= r_fcnt + FW'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = w_tmo ? ST_IDLE :
                 !w_fe ? r_state :
                 r_state == ST_IDLE ? (w_dat ? ST_IDLE : ST_DATA) :
                 r_state == ST_DATA ? (r_bits == 3'd7 ? ST_PARITY : ST_DATA) :
                 r_state == ST_PARITY ? ST_STOP : ST_IDLE;
    end
    always_comb begin
        w_stb = r_state == ST_STOP && w_fe && w_dat && w_par_ok;
        w_err = w_tmo || (w_fe && (r_state == ST_IDLE ? w_dat :
                                   r_state == ST_STOP && !(w_dat && w_par_ok)));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bits    <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tmo     <= '0;
            scan_stb  <= 1'b0;
            scan_byte <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            r_tmo <= (w_fe || w_tmo || r_state == ST_IDLE) ? '0 : r_tmo + TW'(1);
            if (w_fe && r_state == ST_IDLE) r_bits <= '0;
            if (w_fe && r_state == ST_DATA) begin
                r_shift <= {w_dat, r_shift[7:1]};
                r_bits  <= r_bits + 3'd1;
            end
            if (w_fe && r_state == ST_PARITY) r_par <= w_dat;
            scan_stb  <= w_stb;
            frame_err <= w_err;
            if (w_stb) scan_byte <= r_shift;
        end
    end
    ps2_keymap u_map (
        .i_key ({r_ext, scan_byte[6:0]}),
        .o_l3  (w_l3)
    );
    // a break only releases the key currently shown, so the last-pressed key keeps priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            kb_code  <= 8'h00;
            kb_shift <= 1'b0;
            kb_ctrl  <= 1'b0;
        end else if (scan_stb) begin
            if (scan_byte == PS2_EXT) r_ext <= 1'b1;
            else if (scan_byte == PS2_BRK) r_brk <= 1'b1;
            else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
                if (!scan_byte[7]) begin
                    if (!r_ext && (scan_byte == PS2_LSHIFT || scan_byte == PS2_RSHIFT)) kb_shift <= !r_brk;
                    else if (scan_byte == PS2_CTRL) kb_ctrl <= !r_brk;
                    else if (w_l3 != L3_NOKEY) begin
                        if (!r_brk) kb_code <= {1'b1, w_l3};
                        else if (kb_code[6:0] == w_l3) kb_code <= 8'h00;
                    end
                end
            end
        end
    end
endmodule
